sdram_controller_responder: RTL and testbench

//  Behavioural responder for the SDRAM-controller user interface (I_sdrc_*/O_sdrc_*) driven by ramio.

---
 rtl/sdrc_pkg.sv | 29 ++
 rtl/sdram_responder_ram.sv | 27 ++
 rtl/sdram_controller_responder.sv | 212 +++++++++++++++++++++
 tb/tb_sdram_controller_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_pkg.sv
// Shared definitions for the SDRAM-controller responder: command encoding,
// address field widths and the responder FSM state type.
package sdrc_pkg;

  localparam int BankBitWidth = 2;
  localparam int RowBitWidth  = 11;
  localparam int ColBitWidth  = 8;

  // Command encoding {ras_n, cas_n, we_n}; 3'b110 is unused and decodes as a no-op.
  typedef enum logic [2:0] {
    CMD_MRS       = 3'b000,
    CMD_REFRESH   = 3'b001,
    CMD_PRECHARGE = 3'b010,
    CMD_ACTIVATE  = 3'b011,
    CMD_WRITE     = 3'b100,
    CMD_READ      = 3'b101,
    CMD_NOP       = 3'b111
  } sdrc_cmd_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_REFRESH,
    ST_WRITE,
    ST_READ_WAIT,
    ST_READ
  } sdrc_state_e;

endpackage

// File: rtl/sdram_responder_ram.sv
// Single-port 32-bit backing RAM with per-byte write enables and a one-cycle
// registered read port.
module sdram_responder_ram #(
  parameter int AddrWidth = 21
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [AddrWidth-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [0:(1 << AddrWidth)-1];

  // Byte-masked write and registered read of the addressed word.
  // NOTE: the array has no reset; clearing a RAM in reset would turn it into flops and its contents must survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_controller_responder.sv
// Behavioural responder for the SDRAM-controller user interface, backed by
// on-chip RAM. Reproduces the controller's ack/data timing.
// Optional build macro SDRC_RESPONDER_CHECK_EN adds a protocol checker
// (internal sticky flag protocol_error plus $error messages).
module sdram_controller_responder
  import sdrc_pkg::*;
#(
  parameter int AddressBitWidth = 21,
  parameter int InitCycles      = 16,
  parameter int ReadLatency     = 4,   // must be >= 2: RAM read plus output register
  parameter int RefreshCycles   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       O_sdrc_init_done,
  input  logic                       I_sdrc_cmd_en,
  input  logic [2:0]                 I_sdrc_cmd,
  input  logic                       I_sdrc_precharge_ctrl,
  input  logic                       I_sdram_power_down,
  input  logic                       I_sdram_selfrefresh,
  input  logic [AddressBitWidth-1:0] I_sdrc_addr,
  input  logic [3:0]                 I_sdrc_dqm,
  input  logic [31:0]                I_sdrc_data,
  input  logic [7:0]                 I_sdrc_data_len,
  output logic [31:0]                O_sdrc_data,
  output logic                       O_sdrc_cmd_ack
);

  sdrc_state_e state, state_next;
  sdrc_cmd_e   cmd;
  logic [15:0] cyc;          // cycles since entering the current non-idle phase
  logic        accept;
  logic        burst_end;

  logic [BankBitWidth-1:0] cmd_bank;
  logic [RowBitWidth-1:0]  cmd_row;
  logic [ColBitWidth-1:0]  cmd_col;

  logic [3:0]             bank_open;
  logic [RowBitWidth-1:0] bank_row [4];

  logic [BankBitWidth-1:0] bank_l;
  logic [RowBitWidth-1:0]  row_l;
  logic [ColBitWidth-1:0]  col_l;
  logic [7:0]              len_l;
  logic                    pc_l;

  logic [15:0]                rd_off;
  logic                       rd_issue;
  logic                       rd_valid;
  logic [ColBitWidth-1:0]     ram_col;
  logic                       ram_we;
  logic [AddressBitWidth-1:0] ram_addr;
  logic [31:0]                ram_rdata;

  // Power-down and self-refresh are not modelled.
  logic unused_inputs;
  assign unused_inputs = I_sdram_power_down ^ I_sdram_selfrefresh;

  assign cmd      = sdrc_cmd_e'(I_sdrc_cmd);
  assign cmd_bank = I_sdrc_addr[AddressBitWidth-1 -: BankBitWidth];
  assign cmd_row  = I_sdrc_addr[ColBitWidth +: RowBitWidth];
  assign cmd_col  = I_sdrc_addr[ColBitWidth-1:0];
  assign accept   = (state == ST_IDLE) && I_sdrc_cmd_en;

  assign O_sdrc_init_done = (state != ST_INIT);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_next;
  end

  // Next-state decode; burst_end marks the last cycle of a read or write burst.
  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    burst_end  = 1'b0;
    case (state)
      ST_INIT:
        if (cyc == 16'(InitCycles - 1)) state_next = ST_IDLE;
      ST_IDLE:
        if (I_sdrc_cmd_en) begin
          case (cmd)
            CMD_REFRESH: state_next = ST_REFRESH;
            CMD_WRITE:   state_next = ST_WRITE;
            CMD_READ:    state_next = ST_READ_WAIT;
            default:     state_next = ST_IDLE;
          endcase
        end
      ST_REFRESH:
        if (cyc == 16'(RefreshCycles - 1)) state_next = ST_IDLE;
      ST_WRITE:
        if (cyc == {8'd0, len_l}) begin
          state_next = ST_IDLE;
          burst_end  = 1'b1;
        end
      ST_READ_WAIT:
        if (cyc == 16'(ReadLatency - 1)) state_next = ST_READ;
      ST_READ:
        if (cyc == 16'(ReadLatency) + {8'd0, len_l}) begin
          state_next = ST_IDLE;
          burst_end  = 1'b1;
        end
      default:
        state_next = ST_INIT;
    endcase
  end

  // Phase counter: zero in the ack cycle (and after reset), counts while not idle.
  always_ff @(posedge clk) begin
    if (rst)                 cyc <= '0;
    else if (accept)         cyc <= '0;
    else if (state != ST_IDLE) cyc <= cyc + 16'd1;
  end

  // Per-bank open flag and active row.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_open <= '0;
      for (int b = 0; b < 4; b++) bank_row[b] <= '0;
    end else begin
      if (accept && cmd == CMD_ACTIVATE) begin
        bank_row[cmd_bank]  <= cmd_row;
        bank_open[cmd_bank] <= 1'b1;
      end
      if (accept && cmd == CMD_PRECHARGE) begin
        if (I_sdrc_addr[10]) bank_open <= '0;
        else                 bank_open[cmd_bank] <= 1'b0;
      end
      if (burst_end && pc_l) bank_open[bank_l] <= 1'b0;
    end
  end

  // Burst parameters captured when a command is accepted; a closed bank maps to row 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_l <= '0;
      row_l  <= '0;
      col_l  <= '0;
      len_l  <= '0;
      pc_l   <= 1'b0;
    end else if (accept) begin
      bank_l <= cmd_bank;
      row_l  <= bank_open[cmd_bank] ? bank_row[cmd_bank] : '0;
      col_l  <= cmd_col;
      len_l  <= I_sdrc_data_len;
      pc_l   <= I_sdrc_precharge_ctrl;
    end
  end

  // One-cycle acknowledge in the cycle after the command is taken.
  always_ff @(posedge clk) begin
    if (rst) O_sdrc_cmd_ack <= 1'b0;
    else     O_sdrc_cmd_ack <= accept;
  end

  // Read addresses are issued two cycles ahead of their data_out slot to cover
  // the RAM read register and the output register. Columns wrap within 8 bits.
  assign rd_off   = cyc - 16'(ReadLatency - 2);
  assign rd_issue = ((state == ST_READ_WAIT) || (state == ST_READ)) &&
                    (cyc >= 16'(ReadLatency - 2)) && (rd_off <= {8'd0, len_l});
  assign ram_col  = (state == ST_WRITE) ? col_l + cyc[7:0] : col_l + rd_off[7:0];
  assign ram_we   = (state == ST_WRITE);
  assign ram_addr = {bank_l, row_l, ram_col};

  sdram_responder_ram #(.AddrWidth(AddressBitWidth)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (~I_sdrc_dqm),
    .addr  (ram_addr),
    .wdata (I_sdrc_data),
    .rdata (ram_rdata)
  );

  // Output register: loads each read beat and holds the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid    <= 1'b0;
      O_sdrc_data <= '0;
    end else begin
      rd_valid <= rd_issue;
      if (rd_valid) O_sdrc_data <= ram_rdata;
    end
  end

`ifdef SDRC_RESPONDER_CHECK_EN
  logic protocol_error;

  // Sticky protocol checker; observes commands without influencing them.
  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_error <= 1'b0;
    end else if (I_sdrc_cmd_en) begin
      if (state != ST_IDLE) begin
        protocol_error <= 1'b1;
        $error("sdrc responder: cmd_en while not idle (cmd %b)", I_sdrc_cmd);
      end else if ((cmd == CMD_READ || cmd == CMD_WRITE) && !bank_open[cmd_bank]) begin
        protocol_error <= 1'b1;
        $error("sdrc responder: read/write to closed bank %0d", cmd_bank);
      end else if (cmd == CMD_ACTIVATE && bank_open[cmd_bank]) begin
        protocol_error <= 1'b1;
        $error("sdrc responder: activate to open bank %0d", cmd_bank);
      end
    end
  end
`else
  // Checker not built: no flag and no messages.
`endif

endmodule

// File: tb/tb_sdram_controller_responder.sv
// Directed self-checking bench for sdram_controller_responder.
module tb_sdram_controller_responder;
  import sdrc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        cmd_en;
  logic [2:0]  cmd;
  logic        pc;
  logic        power_down;
  logic        selfrefresh;
  logic [20:0] addr;
  logic [3:0]  dqm;
  logic [31:0] wdata;
  logic [7:0]  data_len;
  logic [31:0] rdata;
  logic        ack;

  int checks = 0;
  int errors = 0;

  logic [31:0] wbeat [4];
  logic [3:0]  wdqm  [4];
  logic [31:0] rbeat [4];
  logic [31:0] hold_exp;

  sdram_controller_responder dut (
    .clk                   (clk),
    .rst                   (rst),
    .O_sdrc_init_done      (init_done),
    .I_sdrc_cmd_en         (cmd_en),
    .I_sdrc_cmd            (cmd),
    .I_sdrc_precharge_ctrl (pc),
    .I_sdram_power_down    (power_down),
    .I_sdram_selfrefresh   (selfrefresh),
    .I_sdrc_addr           (addr),
    .I_sdrc_dqm            (dqm),
    .I_sdrc_data           (wdata),
    .I_sdrc_data_len       (data_len),
    .O_sdrc_data           (rdata),
    .O_sdrc_cmd_ack        (ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command for one cycle; returns in the ack cycle.
  task automatic issue(input sdrc_cmd_e c, input logic [1:0] b, input logic [10:0] r,
                       input logic [7:0] col, input logic [7:0] len, input logic p);
    cmd      = c;
    addr     = {b, r, col};
    data_len = len;
    pc       = p;
    cmd_en   = 1'b1;
    tick();
    cmd_en   = 1'b0;
    check("cmd_ack", ack, 1'b1);
  endtask

  task automatic do_write(input logic [1:0] b, input logic [7:0] col, input int len, input logic p);
    issue(CMD_WRITE, b, 11'd0, col, 8'(len), p);
    for (int i = 0; i <= len; i++) begin
      wdata = wbeat[i];
      dqm   = wdqm[i];
      tick();
    end
    wdata = '0;
    dqm   = '0;
  endtask

  // Beat k is expected at ack+4+k; the previous data_out must hold until then.
  task automatic do_read(input logic [1:0] b, input logic [7:0] col, input int len);
    issue(CMD_READ, b, 11'd0, col, 8'(len), 1'b0);
    repeat (3) tick();
    check("read_latency_hold", rdata, hold_exp);
    tick();
    for (int i = 0; i <= len; i++) begin
      check($sformatf("read_beat%0d", i), rdata, rbeat[i]);
      tick();
    end
    check("read_last_hold", rdata, rbeat[len]);
    hold_exp = rbeat[len];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_en = 1'b0; cmd = CMD_NOP; pc = 1'b0; power_down = 1'b0;
    selfrefresh = 1'b0; addr = '0; dqm = '0; wdata = '0; data_len = '0;
    for (int i = 0; i < 4; i++) wdqm[i] = 4'b0000;
    hold_exp = 32'h0;

    // Reset state.
    repeat (3) tick();
    check("rst_init_done", init_done, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_data", rdata, 32'h0);

    // Init countdown with cmd_en held high: ignored throughout.
    rst = 1'b0;
    cmd = CMD_NOP;
    cmd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("init_low_c%0d", i), init_done, 1'b0);
      check($sformatf("init_no_ack_c%0d", i), ack, 1'b0);
      tick();
    end
    cmd_en = 1'b0;
    check("init_done_rise", init_done, 1'b1);
    check("init_cmd_ignored", ack, 1'b0);
    tick();
    check("init_cmd_ignored2", ack, 1'b0);

    // ACTIVATE bank1 row5, write/read back a 4-beat burst.
    issue(CMD_ACTIVATE, 2'd1, 11'd5, 8'd0, 8'd0, 1'b0);
    tick();
    check("ack_one_cycle", ack, 1'b0);
    wbeat[0] = 32'h11111111; wbeat[1] = 32'h22222222;
    wbeat[2] = 32'h33333333; wbeat[3] = 32'h44444444;
    do_write(2'd1, 8'd0, 3, 1'b0);
    rbeat = wbeat;
    do_read(2'd1, 8'd0, 3);

    // Column wrap and per-beat byte mask.
    for (int i = 0; i < 4; i++) wbeat[i] = 32'hDEADBEEF;
    do_write(2'd1, 8'd254, 3, 1'b0);
    wbeat[0] = 32'h01010101; wbeat[1] = 32'h02020202;
    wbeat[2] = 32'h03030303; wbeat[3] = 32'h04040404;
    wdqm[1] = 4'b1110;
    do_write(2'd1, 8'd254, 3, 1'b0);
    wdqm[1] = 4'b0000;
    rbeat[0] = 32'h01010101; rbeat[1] = 32'hDEADBE02;
    rbeat[2] = 32'h03030303; rbeat[3] = 32'h04040404;
    do_read(2'd1, 8'd254, 3);
    rbeat[0] = 32'h03030303; rbeat[1] = 32'h04040404;
    do_read(2'd1, 8'd0, 1);

    // REFRESH: commands in the 8 busy cycles are ignored, the 9th is acked.
    issue(CMD_REFRESH, 2'd0, 11'd0, 8'd0, 8'd0, 1'b0);
    cmd = CMD_NOP;
    cmd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("refresh_busy_c%0d", i), ack, 1'b0);
    end
    tick();
    check("refresh_release_ack", ack, 1'b1);
    cmd_en = 1'b0;
    tick();

    // PRECHARGE bank1: a write to the closed bank lands in row 0.
    issue(CMD_PRECHARGE, 2'd1, 11'd0, 8'd0, 8'd0, 1'b0);
    wbeat[0] = 32'h5A5A5A5A;
    do_write(2'd1, 8'd0, 0, 1'b0);
    issue(CMD_ACTIVATE, 2'd1, 11'd0, 8'd0, 8'd0, 1'b0);
    rbeat[0] = 32'h5A5A5A5A;
    do_read(2'd1, 8'd0, 0);
    issue(CMD_ACTIVATE, 2'd1, 11'd5, 8'd0, 8'd0, 1'b0);
    rbeat[0] = 32'h03030303;
    do_read(2'd1, 8'd0, 0);

    // Auto-precharge closes the bank after the burst.
    wbeat[0] = 32'h77777777;
    do_write(2'd1, 8'd10, 0, 1'b1);
    wbeat[0] = 32'h99999999;
    do_write(2'd1, 8'd10, 0, 1'b0);
    issue(CMD_ACTIVATE, 2'd1, 11'd5, 8'd0, 8'd0, 1'b0);
    rbeat[0] = 32'h77777777;
    do_read(2'd1, 8'd10, 0);

    // Precharge-all (addr[10]=1) issued to bank0 also closes bank1.
    issue(CMD_PRECHARGE, 2'd0, 11'h004, 8'd0, 8'd0, 1'b0);
    wbeat[0] = 32'hAAAAAAAA;
    do_write(2'd1, 8'd10, 0, 1'b0);
    issue(CMD_ACTIVATE, 2'd1, 11'd0, 8'd0, 8'd0, 1'b0);
    rbeat[0] = 32'hAAAAAAAA;
    do_read(2'd1, 8'd10, 0);

    // Reset in the middle of a read burst, then re-init and read back.
    issue(CMD_ACTIVATE, 2'd1, 11'd5, 8'd0, 8'd0, 1'b0);
    issue(CMD_READ, 2'd1, 11'd0, 8'd254, 8'd3, 1'b0);
    repeat (5) tick();
    check("mid_read_beat1", rdata, 32'hDEADBE02);
    rst = 1'b1;
    tick();
    check("mid_rst_data", rdata, 32'h0);
    check("mid_rst_init_done", init_done, 1'b0);
    check("mid_rst_ack", ack, 1'b0);
    rst = 1'b0;
    repeat (16) tick();
    check("reinit_done", init_done, 1'b1);
    hold_exp = 32'h0;
    issue(CMD_ACTIVATE, 2'd1, 11'd5, 8'd0, 8'd0, 1'b0);
    rbeat[0] = 32'h01010101; rbeat[1] = 32'hDEADBE02;
    rbeat[2] = 32'h03030303; rbeat[3] = 32'h04040404;
    do_read(2'd1, 8'd254, 3);

`ifdef SDRC_RESPONDER_CHECK_EN
    // READ to a just-precharged bank raises the sticky protocol flag.
    check("perr_clear", dut.protocol_error, 1'b0);
    issue(CMD_PRECHARGE, 2'd1, 11'd0, 8'd0, 8'd0, 1'b0);
    issue(CMD_READ, 2'd1, 11'd0, 8'd0, 8'd0, 1'b0);
    check("perr_set", dut.protocol_error, 1'b1);
    repeat (8) tick();
    check("perr_sticky", dut.protocol_error, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
